// File: rtl/core_pkg.sv
// Shared fetch-stage definitions: NOP encoding, default boot address,
// fetch FSM states and the {pc, insn} entry held by the fetch FIFO.
package core_pkg;

  localparam logic [31:0] NOP              = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_BASEADDR = 32'h0100_0000;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry FIFO of fetched {pc, insn} words. Entry 0 is always the head,
// so a pop simply shifts entry 1 down.
module fetch_fifo #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [1:0]   count
);

  logic [W-1:0] ent0;
  logic [W-1:0] ent1;
  logic [1:0]   cnt;
  logic         do_pop;
  logic         do_push;

  assign do_pop  = pop && (cnt != 2'd0);
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push && ((cnt != 2'd2) || do_pop);
  assign head    = ent0;
  assign count   = cnt;

  // Storage and occupancy update; flush empties the queue.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= 2'd0;
      ent0 <= '0;
      ent1 <= '0;
    end else if (flush) begin
      cnt <= 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (cnt == 2'd0) begin
            ent0 <= push_data;
          end else begin
            ent1 <= push_data;
          end
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          ent0 <= ent1;
          cnt  <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            ent0 <= push_data;
          end else begin
            ent0 <= ent1;
            ent1 <= push_data;
          end
        end
        default: begin
          cnt <= cnt;
        end
      endcase
    end
  end

endmodule

// File: rtl/fetch.sv
// Instruction fetch stage: issues sequential reads, queues responses for decode.
// Optional misaligned-redirect fault enabled by macro FETCH_ALIGN_CHECK_EN.
module fetch
  import core_pkg::*;
#(
  parameter int                DWIDTH   = 32,
  parameter int                AWIDTH   = 32,
  parameter logic [AWIDTH-1:0] BASEADDR = AWIDTH'(DEFAULT_BASEADDR)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_o,
  output logic [AWIDTH-1:0] imem_addr_o,
  input  logic              imem_rvalid_i,
  input  logic [DWIDTH-1:0] imem_rdata_i,
  input  logic              redirect_i,
  input  logic [AWIDTH-1:0] redirect_pc_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [AWIDTH-1:0] pc_o,
  output logic [DWIDTH-1:0] insn_o,
  output logic              fault_o
);

  fetch_state_t               state;
  logic [AWIDTH-1:0]          fetch_pc;
  logic [AWIDTH-1:0]          req_pc;
  logic                       outstanding;
  logic                       fault;
  logic [1:0]                 count;
  logic [AWIDTH+DWIDTH-1:0]   head;
  logic [AWIDTH+DWIDTH-1:0]   push_data;
  logic                       not_empty;
  logic                       pop;
  logic                       push;
  logic                       issue;
  logic                       misaligned;
  logic [AWIDTH-1:0]          target;
  logic [2:0]                 credit;

`ifdef FETCH_ALIGN_CHECK_EN
  assign misaligned = redirect_i && (redirect_pc_i[1:0] != 2'b00);
  assign target     = redirect_pc_i;
`else
  assign misaligned = 1'b0;
  assign target     = redirect_pc_i & ~(AWIDTH'(32'd3));
`endif

  assign not_empty = (count != 2'd0);
  assign pop       = not_empty && ready_i && !redirect_i;
  // The response is only kept if it belongs to a request still considered live.
  assign push      = imem_rvalid_i && outstanding && !redirect_i && !rst;
  assign push_data = {req_pc, imem_rdata_i};
  // Credit counts the slot freed by this cycle's pop so ready_i high sustains one fetch per cycle.
  assign credit    = {1'b0, count} + {2'b00, outstanding} - {2'b00, pop};
  assign issue     = (state == RUN) && !rst && !redirect_i && (credit < 3'd2);

  assign imem_req_o  = issue;
  assign imem_addr_o = rst ? BASEADDR : fetch_pc;
  assign valid_o     = not_empty && !rst;
  assign pc_o        = valid_o ? head[AWIDTH+DWIDTH-1:DWIDTH] : '0;
  assign insn_o      = valid_o ? head[DWIDTH-1:0] : DWIDTH'(NOP);
  assign fault_o     = fault && !rst;

  fetch_fifo #(
    .W(AWIDTH + DWIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_i),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  // Control FSM with fetch PC, in-flight request tracking and sticky fault.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= BOOT;
      fetch_pc    <= BASEADDR;
      req_pc      <= BASEADDR;
      outstanding <= 1'b0;
      fault       <= 1'b0;
    end else begin
      outstanding <= issue;
      if (issue) begin
        req_pc   <= fetch_pc;
        fetch_pc <= fetch_pc + AWIDTH'(32'd4);
      end
      case (state)
        BOOT: begin
          if (misaligned) begin
            state <= FAULT;
            fault <= 1'b1;
          end else begin
            state <= RUN;
            if (redirect_i) begin
              fetch_pc <= target;
            end
          end
        end
        RUN: begin
          if (misaligned) begin
            state <= FAULT;
            fault <= 1'b1;
          end else if (redirect_i) begin
            fetch_pc <= target;
          end
        end
        FAULT: begin
          state <= FAULT;
        end
        default: begin
          state <= BOOT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch.sv
// Self-checking bench for fetch: directed scenarios plus random traffic,
// compared each cycle against a queue-based model of the fetch stream.
module tb_fetch;
  import core_pkg::*;

  localparam logic [31:0] BASE = 32'h0100_0000;
  localparam int M_BOOT  = 0;
  localparam int M_RUN   = 1;
  localparam int M_FAULT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = 32'h0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'h0;
  logic        valid_o;
  logic        ready_i = 1'b0;
  logic [31:0] pc_o;
  logic [31:0] insn_o;
  logic        fault_o;

  int vectors = 0;
  int miscompares = 0;

  // model of the fetch stream
  fetch_entry_t mq[$];
  logic [31:0]  m_infl[$];
  logic [31:0]  m_pc = BASE;
  int           m_phase = M_BOOT;
  logic         m_faulted = 1'b0;

  // memory side
  logic        mem_pend = 1'b0;
  logic [31:0] mem_addr = 32'h0;

  int cyc = 0;
  int first_req = 0;
  int first_valid = 0;
  logic [31:0] first_addr = 32'h0;

  fetch dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .pc_o          (pc_o),
    .insn_o        (insn_o),
    .fault_o       (fault_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step(input logic r, input logic rdy, input logic redir, input logic [31:0] tgt);
    logic        e_valid, e_pop, e_req, e_fault, mis, have_resp;
    logic [31:0] e_pc, e_insn, e_addr;
    int          occ;
    fetch_entry_t ent;
    @(negedge clk);
    rst           = r;
    ready_i       = rdy;
    redirect_i    = redir;
    redirect_pc_i = tgt;
    imem_rvalid_i = mem_pend;
    imem_rdata_i  = mem_pend ? word_at(mem_addr) : 32'hDEAD_BEEF;
    #1;
    e_valid = !r && (mq.size() != 0);
    e_pc    = e_valid ? mq[0].pc : 32'h0;
    e_insn  = e_valid ? mq[0].insn : NOP;
    e_fault = !r && m_faulted;
    e_pop   = e_valid && rdy;
    occ     = mq.size() - (e_pop ? 1 : 0) + m_infl.size();
    e_req   = !r && (m_phase == M_RUN) && !redir && (occ < 2);
    e_addr  = r ? BASE : m_pc;
    check_value("valid", {63'd0, valid_o}, {63'd0, e_valid});
    check_value("pc", {32'd0, pc_o}, {32'd0, e_pc});
    check_value("insn", {32'd0, insn_o}, {32'd0, e_insn});
    check_value("fault", {63'd0, fault_o}, {63'd0, e_fault});
    check_value("req", {63'd0, imem_req_o}, {63'd0, e_req});
    check_value("addr", {32'd0, imem_addr_o}, {32'd0, e_addr});
`ifdef FETCH_ALIGN_CHECK_EN
    mis = redir && (tgt[1:0] != 2'b00);
`else
    mis = 1'b0;
`endif
    if (r) begin
      mq.delete();
      m_infl.delete();
      m_pc      = BASE;
      m_phase   = M_BOOT;
      m_faulted = 1'b0;
    end else begin
      have_resp = (m_infl.size() != 0);
      if (redir) begin
        mq.delete();
        m_infl.delete();
        if (mis && m_phase != M_FAULT) begin
          m_phase   = M_FAULT;
          m_faulted = 1'b1;
        end else if (m_phase != M_FAULT) begin
          m_pc = tgt & 32'hFFFF_FFFC;
        end
      end else begin
        if (e_pop) void'(mq.pop_front());
        if (have_resp) begin
          ent.pc   = m_infl[0];
          ent.insn = word_at(m_infl[0]);
          mq.push_back(ent);
        end
        m_infl.delete();
        if (e_req) begin
          m_infl.push_back(m_pc);
          m_pc = m_pc + 32'd4;
        end
      end
      if (m_phase == M_BOOT) m_phase = M_RUN;
    end
    mem_pend = imem_req_o;
    mem_addr = imem_addr_o;
    if (r) begin
      cyc = 0;
      first_req = 0;
      first_valid = 0;
    end else begin
      cyc++;
      if (first_req == 0 && imem_req_o) begin
        first_req  = cyc;
        first_addr = imem_addr_o;
      end
      if (first_valid == 0 && valid_o) first_valid = cyc;
    end
  endtask

  initial begin
    logic seen;
    logic [31:0] tgt;
    int sel;

    // reset release and streaming
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0, 32'h0);
    check_value("first_req_cyc", 64'(first_req), 64'd2);
    check_value("first_addr", {32'd0, first_addr}, {32'd0, BASE});
    check_value("first_valid_cyc", 64'(first_valid), 64'd4);

    // decode stall saturates the FIFO
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
    check_value("stall_req", {63'd0, imem_req_o}, 64'd0);
    check_value("stall_valid", {63'd0, valid_o}, 64'd1);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 32'h0);

    // redirect with a response in flight
    step(1'b0, 1'b1, 1'b1, 32'h0100_0040);
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      step(1'b0, 1'b1, 1'b0, 32'h0);
      if (valid_o) begin
        seen = 1'b1;
        check_value("redir_pc", {32'd0, pc_o}, 64'h0100_0040);
      end
    end
    if (!seen) check_value("redir_timeout", 64'd0, 64'd1);

    // redirect coinciding with pop and push
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b1, 32'h0100_0080);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    check_value("flush_valid", {63'd0, valid_o}, 64'd0);
    check_value("flush_insn", {32'd0, insn_o}, 64'h0000_0013);

    // misaligned redirect
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b1, 32'h0100_0042);
    step(1'b0, 1'b1, 1'b0, 32'h0);
`ifdef FETCH_ALIGN_CHECK_EN
    for (int i = 0; i < 4; i++) begin
      check_value("fault_sticky", {63'd0, fault_o}, 64'd1);
      check_value("fault_noreq", {63'd0, imem_req_o}, 64'd0);
      step(1'b0, 1'b1, 1'b0, 32'h0);
    end
`else
    check_value("align_req", {63'd0, imem_req_o}, 64'd1);
    check_value("align_addr", {32'd0, imem_addr_o}, 64'h0100_0040);
`endif

    // reset pulse during streaming
    step(1'b1, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    check_value("rst_valid", {63'd0, valid_o}, 64'd0);
    check_value("rst_addr", {32'd0, imem_addr_o}, {32'd0, BASE});
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 32'h0);
    check_value("refetch_addr", {32'd0, first_addr}, {32'd0, BASE});

    // random traffic
    for (int i = 0; i < 400; i++) begin
      sel = int'($urandom_range(0, 19));
      if (sel == 0) tgt = 32'hFFFF_FFF8;
      else if (sel == 1) tgt = BASE + 32'd2 + 32'($urandom_range(0, 15)) * 32'd4;
      else tgt = BASE + 32'($urandom_range(0, 63)) * 32'd4;
      step(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 70),
           ($urandom_range(0, 99) < 8), tgt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
